sequenciador_passos: RTL and testbench

- Upstream neighbour of the control unit.
- Buffers incoming 16-bit instructions in a small FIFO and latches one into the instruction register.
- Drives the 2-bit step counter 00→01→10→11 that sequences execution, and honours the control unit's clear request.
- Provides the control unit's `instrucao` and `step` inputs and consumes its `clear` output.

---
 rtl/sequenciador_passos_pkg.sv | 19 +
 rtl/sequenciador_passos_if.sv | 24 ++
 rtl/sequenciador_passos_fila_instr.sv | 44 ++++
 rtl/sequenciador_passos.sv | 65 ++++++
 tb/tb_sequenciador_passos.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/sequenciador_passos_pkg.sv
// sequenciador_passos_pkg: shared widths, step codes, FSM states and opcodes
package sequenciador_passos_pkg;
   localparam int INSTR_W = 16;
   localparam logic [1:0] STEP0 = 2'b00;
   localparam logic [1:0] STEP1 = 2'b01;
   localparam logic [1:0] STEP2 = 2'b10;
   localparam logic [1:0] STEP3 = 2'b11;
   typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} estado_t;
   // Opcodes live in the top nibble; decoded only by the control unit
   localparam logic [3:0] ADD = 4'h0;
   localparam logic [3:0] SUB = 4'h1;
   localparam logic [3:0] NAN = 4'h2;
   localparam logic [3:0] OUT = 4'h3;
   localparam logic [3:0] LDI = 4'h4;
   localparam logic [3:0] REP = 4'h5;
   function automatic logic [3:0] opcode(input logic [INSTR_W-1:0] i_instr);
      return i_instr[INSTR_W-1 -: 4];
   endfunction
endpackage

// File: rtl/sequenciador_passos_if.sv
// sequenciador_passos_if: instruction source, control-unit and status signals
interface sequenciador_passos_if #(
   parameter int INSTR_W = sequenciador_passos_pkg::INSTR_W,
   parameter int CNT_W   = 3
);
   logic [INSTR_W-1:0] in_instr;
   logic               in_valid;
   logic               in_ready;
   logic               run;
   logic               clear;
   logic [INSTR_W-1:0] instrucao;
   logic [1:0]         step;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   fifo_count;
   modport master (
      output in_instr, in_valid, run, clear,
      input  in_ready, instrucao, step, busy, done, fifo_count
   );
   modport slave (
      input  in_instr, in_valid, run, clear,
      output in_ready, instrucao, step, busy, done, fifo_count
   );
endinterface

// File: rtl/sequenciador_passos_fila_instr.sv
// fila_instr: synchronous instruction FIFO, no bypass, pushes ignored when full
module fila_instr #(
   parameter int W     = 16,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [W-1:0]     i_din,
   output logic [W-1:0]     o_dout,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]     r_mem [DEPTH];
   logic [AW-1:0]    r_wr;
   logic [AW-1:0]    r_rd;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_full  = r_count == CNT_W'(DEPTH);
   assign o_empty = r_count == '0;
   assign o_count = r_count;
   assign o_dout  = r_mem[r_rd];
   always_ff @(posedge clock) begin
      if (reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end
   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wr] <= i_din;
   end
endmodule

// File: rtl/sequenciador_passos.sv
// sequenciador_passos: buffers instructions, latches the instruction register
// and sequences the 4-step execution counter for the control unit.
module sequenciador_passos
   import sequenciador_passos_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 3
) (
   input logic                 clock,
   input logic                 reset,
   sequenciador_passos_if.slave bus
);
   estado_t            r_state;
   logic [1:0]         r_step;
   logic [INSTR_W-1:0] r_instr;
   logic               r_done;
   logic [INSTR_W-1:0] w_head;
   logic [CNT_W-1:0]   w_count;
   logic               w_full;
   logic               w_empty;
   logic               w_start;
   logic               w_pop;
   // run is only consulted at an instruction boundary
   assign w_start = bus.run && !w_empty && (r_state == IDLE || (r_state == EXEC && r_step == STEP3));
   assign w_pop   = w_start && !bus.clear;
   fila_instr #(.W(INSTR_W), .DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fila (
      .clock   (clock),
      .reset   (reset),
      .i_push  (bus.in_valid),
      .i_pop   (w_pop),
      .i_din   (bus.in_instr),
      .o_dout  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
         r_step  <= STEP0;
         r_instr <= '0;
         r_done  <= 1'b0;
      end else if (bus.clear) begin
         r_state <= IDLE;
         r_step  <= STEP0;
         r_done  <= 1'b0;
      end else begin
         r_done <= r_state == EXEC && r_step == STEP2;
         if (w_start) begin
            r_instr <= w_head;
            r_step  <= STEP0;
            r_state <= EXEC;
         end else if (r_state == EXEC) begin
            r_step <= r_step + 2'd1;
            if (r_step == STEP3) r_state <= IDLE;
         end
      end
   end
   assign bus.in_ready   = !w_full;
   assign bus.instrucao  = r_instr;
   assign bus.step       = r_step;
   assign bus.busy       = r_state == EXEC;
   assign bus.done       = r_done;
   assign bus.fifo_count = w_count;
endmodule

// File: tb/tb_sequenciador_passos.sv
// tb_sequenciador_passos: directed stimulus with a queue-based execution scoreboard
module tb_sequenciador_passos;
   logic clock = 1'b0;
   logic reset;
   int n_tests = 0;
   int n_fail = 0;
   int n_busy = 0;
   int n_rise = 0;
   int n_done = 0;
   logic mon_en = 1'b0;
   logic prev_busy = 1'b0;
   logic [1:0] mon_step = 2'd0;
   logic [15:0] exp_q [$];
   logic [15:0] exp_w;

   sequenciador_passos_if bus ();
   sequenciador_passos #(.FIFO_DEPTH(4), .CNT_W(3)) dut (.clock(clock), .reset(reset), .bus(bus));

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      bus.in_instr = w;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int k = 0;
      while (bus.busy && k < lim) begin
         tick();
         k++;
      end
      if (bus.busy) check("wait_idle timeout", 1, 0);
   endtask

   task automatic zero_counts();
      n_busy = 0;
      n_rise = 0;
      n_done = 0;
   endtask

   // Monitor: every new step 00 must present the next queued instruction
   always @(negedge clock) begin
      if (mon_en) begin
         if (bus.busy) begin
            if (bus.step == 2'd0) begin
               if (exp_q.size() == 0) check("unexpected start", 32'(bus.instrucao), 32'hFFFF_FFFF);
               else begin
                  exp_w = exp_q.pop_front();
                  check("sb instrucao", 32'(bus.instrucao), 32'(exp_w));
               end
               mon_step = 2'd1;
            end else begin
               check("sb step", 32'(bus.step), 32'(mon_step));
               mon_step = mon_step + 2'd1;
            end
            check("sb done", 32'(bus.done), 32'(bus.step == 2'd3));
            n_busy++;
            if (!prev_busy) n_rise++;
         end else begin
            check("idle step", 32'(bus.step), 0);
            check("idle done", 32'(bus.done), 0);
         end
         if (bus.done) n_done++;
         prev_busy = bus.busy;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.run = 1'b0;
      bus.clear = 1'b0;
      tick();
      tick();
      check("rst fifo_count", 32'(bus.fifo_count), 0);
      check("rst in_ready", 32'(bus.in_ready), 1);
      check("rst instrucao", 32'(bus.instrucao), 0);
      check("rst step", 32'(bus.step), 0);
      check("rst busy", 32'(bus.busy), 0);
      check("rst done", 32'(bus.done), 0);
      reset = 1'b0;
      mon_en = 1'b1;
      // single instruction timing
      bus.run = 1'b1;
      exp_q.push_back(16'hA123);
      push(16'hA123);
      tick();
      check("t1 busy c2", 32'(bus.busy), 1);
      check("t1 instr c2", 32'(bus.instrucao), 32'hA123);
      check("t1 step c2", 32'(bus.step), 0);
      check("t1 done c2", 32'(bus.done), 0);
      repeat (3) tick();
      check("t1 step c5", 32'(bus.step), 3);
      check("t1 done c5", 32'(bus.done), 1);
      tick();
      check("t1 busy c6", 32'(bus.busy), 0);
      check("t1 step c6", 32'(bus.step), 0);
      check("t1 done c6", 32'(bus.done), 0);
      // back-to-back
      zero_counts();
      exp_q.push_back(16'h1111);
      exp_q.push_back(16'h2222);
      exp_q.push_back(16'h3333);
      push(16'h1111);
      push(16'h2222);
      push(16'h3333);
      wait_idle(40);
      check("t2 busy cycles", n_busy, 12);
      check("t2 starts", n_rise, 1);
      check("t2 fifo_count", 32'(bus.fifo_count), 0);
      // fill to full, 5th dropped
      bus.run = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(16'hC001 + 16'(i));
         push(16'hC001 + 16'(i));
      end
      check("t3 fifo_count full", 32'(bus.fifo_count), 4);
      check("t3 in_ready full", 32'(bus.in_ready), 0);
      push(16'hC005);
      check("t3 fifo_count after drop", 32'(bus.fifo_count), 4);
      check("t3 busy while run0", 32'(bus.busy), 0);
      zero_counts();
      bus.run = 1'b1;
      tick();
      wait_idle(40);
      check("t3 busy cycles", n_busy, 16);
      check("t3 starts", n_rise, 1);
      check("t3 fifo_count end", 32'(bus.fifo_count), 0);
      check("t3 in_ready end", 32'(bus.in_ready), 1);
      // clear at step 10
      zero_counts();
      exp_q.push_back(16'hD0D0);
      exp_q.push_back(16'hB0B0);
      push(16'hD0D0);
      push(16'hB0B0);
      tick();
      tick();
      check("t4 step before clear", 32'(bus.step), 2);
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      check("t4 busy after clear", 32'(bus.busy), 0);
      check("t4 step after clear", 32'(bus.step), 0);
      check("t4 done after clear", 32'(bus.done), 0);
      check("t4 instr kept", 32'(bus.instrucao), 32'hD0D0);
      tick();
      check("t4 no done for aborted", n_done, 0);
      check("t4 restart busy", 32'(bus.busy), 1);
      check("t4 restart instr", 32'(bus.instrucao), 32'hB0B0);
      wait_idle(20);
      check("t4 done pulses", n_done, 1);
      check("t4 starts", n_rise, 2);
      check("t4 fifo_count", 32'(bus.fifo_count), 0);
      // run dropped mid-instruction
      zero_counts();
      exp_q.push_back(16'h5151);
      push(16'h5151);
      push(16'h5252);
      tick();
      check("t5 step at run drop", 32'(bus.step), 1);
      bus.run = 1'b0;
      wait_idle(20);
      check("t5 busy cycles", n_busy, 4);
      check("t5 fifo_count", 32'(bus.fifo_count), 1);
      repeat (4) tick();
      check("t5 stays idle", 32'(bus.busy), 0);
      check("t5 busy cycles later", n_busy, 4);
      // reset mid-instruction
      push(16'h6161);
      push(16'h6262);
      check("t6 fifo_count queued", 32'(bus.fifo_count), 3);
      exp_q.push_back(16'h5252);
      bus.run = 1'b1;
      tick();
      tick();
      check("t6 step before reset", 32'(bus.step), 1);
      check("t6 fifo_count before reset", 32'(bus.fifo_count), 2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t6 fifo_count", 32'(bus.fifo_count), 0);
      check("t6 step", 32'(bus.step), 0);
      check("t6 instrucao", 32'(bus.instrucao), 0);
      check("t6 busy", 32'(bus.busy), 0);
      check("t6 in_ready", 32'(bus.in_ready), 1);
      zero_counts();
      repeat (8) tick();
      check("t6 nothing runs", n_busy, 0);
      check("scoreboard drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
